// File: rtl/square32_root_checker.sv
// Iterative radix-2 squarer that checks a candidate root P against its radicand I.
// Takes P_N cycles to compute P*P, then one cycle to flag P when it is not floor(sqrt(I)).
module square32_root_checker #(
    parameter int P_N = 16
) (
    input  logic               iCLOCK,
    input  logic               iRESET_SYNC,
    input  logic               iDATA_REQ,
    output logic               oDATA_BUSY,
    input  logic [P_N-1:0]     iDATA_P,
    input  logic [2*P_N-1:0]   iDATA_I,
    output logic               oDATA_VALID,
    input  logic               iDATA_BUSY,
    output logic [2*P_N-1:0]   oDATA_SQ,
    output logic [2*P_N-1:0]   oDATA_REM,
    output logic               oDATA_ERR
);

    localparam int W  = 2 * P_N;
    localparam int CW = $clog2(P_N);

    typedef enum logic [1:0] {IDLE, CALC, CHECK, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [P_N-1:0] p_q, p_d;
    logic [W-1:0]   i_q, i_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   sq_q, sq_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;

    logic [W-1:0]   partial;
    logic [W-1:0]   diff;
    logic [W-1:0]   two_p;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        i_d     = i_q;
        acc_d   = acc_q;
        sq_d    = sq_q;
        rem_d   = rem_q;
        err_d   = err_q;
        partial = {{P_N{1'b0}}, p_q} << cnt_q;
        diff    = i_q - acc_q;
        // 2P as a zero-extended P_N+1-bit quantity: the largest remainder a floor root allows
        two_p   = {{(W-P_N-1){1'b0}}, p_q, 1'b0};

        case (state_q)
            IDLE: begin
                if (iDATA_REQ) begin
                    p_d     = iDATA_P;
                    i_d     = iDATA_I;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (p_q[cnt_q]) begin
                    acc_d = acc_q + partial;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(P_N-1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                sq_d = acc_q;
                if (acc_q > i_q) begin
                    rem_d = '0;
                    err_d = 1'b1;
                end else begin
                    rem_d = diff;
                    err_d = (diff > two_p);
                end
                state_d = DONE;
            end
            DONE: begin
                if (!iDATA_BUSY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            sq_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            sq_q    <= sq_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign oDATA_BUSY  = busy_q;
    assign oDATA_VALID = valid_q;
    assign oDATA_SQ    = sq_q;
    assign oDATA_REM   = rem_q;
    assign oDATA_ERR   = err_q;

endmodule

// File: tb/tb_square32_root_checker.sv
// Directed bench for square32_root_checker: an arithmetic reference model checked every cycle,
// plus literal expectations for each directed operand pair.
module tb_square32_root_checker;

    localparam int P_N = 16;
    localparam int W   = 2 * P_N;
    localparam int LAT = P_N + 1;

    logic           iCLOCK = 1'b0;
    logic           iRESET_SYNC = 1'b1;
    logic           iDATA_REQ = 1'b0;
    logic           oDATA_BUSY;
    logic [P_N-1:0] iDATA_P = '0;
    logic [W-1:0]   iDATA_I = '0;
    logic           oDATA_VALID;
    logic           iDATA_BUSY = 1'b0;
    logic [W-1:0]   oDATA_SQ;
    logic [W-1:0]   oDATA_REM;
    logic           oDATA_ERR;

    square32_root_checker #(.P_N(P_N)) dut (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iDATA_REQ   (iDATA_REQ),
        .oDATA_BUSY  (oDATA_BUSY),
        .iDATA_P     (iDATA_P),
        .iDATA_I     (iDATA_I),
        .oDATA_VALID (oDATA_VALID),
        .iDATA_BUSY  (iDATA_BUSY),
        .oDATA_SQ    (oDATA_SQ),
        .oDATA_REM   (oDATA_REM),
        .oDATA_ERR   (oDATA_ERR)
    );

    always #5 iCLOCK = ~iCLOCK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing (fixed latency), 2 result held
    int             m_phase = 0;
    int             m_left  = 0;
    int             m_accepts = 0;
    int             cyc = 0;
    logic [63:0]    m_p = 0, m_i = 0;
    logic [63:0]    m_sq = 0, m_rem = 0;
    logic           m_err = 1'b0;
    logic           m_busy, m_valid;

    assign m_busy  = (m_phase != 0);
    assign m_valid = (m_phase == 2);

    always @(posedge iCLOCK) begin
        cyc++;
        if (iRESET_SYNC) begin
            m_phase = 0;
            m_sq    = 0;
            m_rem   = 0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                0: if (iDATA_REQ) begin
                    m_p = 64'(iDATA_P);
                    m_i = 64'(iDATA_I);
                    m_left = LAT;
                    m_phase = 1;
                    m_accepts++;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_sq = m_p * m_p;
                        if (m_sq > m_i) begin
                            m_rem = 0;
                            m_err = 1'b1;
                        end else begin
                            m_rem = m_i - m_sq;
                            m_err = (m_rem > 2 * m_p);
                        end
                        m_phase = 2;
                    end
                end
                default: if (!iDATA_BUSY) m_phase = 0;
            endcase
        end
    end

    logic        chk_en = 1'b0;
    logic        prev_v = 1'b0;
    int          vrise_q[$];
    logic [W-1:0] vsq_q[$];

    always @(negedge iCLOCK) begin
        if (chk_en) begin
            check("busy", 64'(oDATA_BUSY), 64'(m_busy));
            check("valid", 64'(oDATA_VALID), 64'(m_valid));
            check("sq", 64'(oDATA_SQ), m_sq);
            check("rem", 64'(oDATA_REM), m_rem);
            check("err", 64'(oDATA_ERR), 64'(m_err));
        end
        if (oDATA_VALID && !prev_v) begin
            vrise_q.push_back(cyc);
            vsq_q.push_back(oDATA_SQ);
        end
        prev_v = oDATA_VALID;
    end

    // Issue one request from IDLE and wait (bounded) for valid; lat counts edges after the accept edge
    task automatic do_op(input logic [P_N-1:0] p, input logic [W-1:0] i, output int lat);
        @(negedge iCLOCK);
        iDATA_REQ = 1'b1;
        iDATA_P = p;
        iDATA_I = i;
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        iDATA_REQ = 1'b0;
        lat = 0;
        while (!oDATA_VALID && lat < 100) begin
            @(posedge iCLOCK);
            lat++;
            @(negedge iCLOCK);
        end
        if (!oDATA_VALID) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout: no valid after %0d edges, expected one", lat);
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] sq, input logic [W-1:0] rem,
                                input logic err);
        check({tag, "_sq"}, 64'(oDATA_SQ), 64'(sq));
        check({tag, "_rem"}, 64'(oDATA_REM), 64'(rem));
        check({tag, "_err"}, 64'(oDATA_ERR), 64'(err));
        check({tag, "_model_sq"}, m_sq, 64'(sq));
        check({tag, "_model_err"}, 64'(m_err), 64'(err));
    endtask

    int lat;
    int base;
    int k;

    initial begin
        repeat (3) @(posedge iCLOCK);
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", 64'(oDATA_BUSY), 0);
        check("rst_valid", 64'(oDATA_VALID), 0);
        check("rst_sq", 64'(oDATA_SQ), 0);

        // Basic operation with latency and single-cycle valid
        do_op(16'h0005, 32'h0000001A, lat);
        check("latency", 64'(lat), 17);
        check_result("p5", 32'h19, 32'h1, 1'b0);
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        check("valid_one_cycle", 64'(oDATA_VALID), 0);
        check("busy_after_done", 64'(oDATA_BUSY), 0);
        check("hold_after_consume", 64'(oDATA_SQ), 64'h19);

        do_op(16'hFFFF, 32'hFFFFFFFF, lat);
        check_result("pmax", 32'hFFFE0001, 32'h0001FFFE, 1'b0);
        do_op(16'h0003, 32'h8, lat);
        check_result("p3_over", 32'h9, 32'h0, 1'b1);
        do_op(16'h0002, 32'h9, lat);
        check_result("p2_rem", 32'h4, 32'h5, 1'b1);
        do_op(16'h0000, 32'h0, lat);
        check_result("p0", 32'h0, 32'h0, 1'b0);
        do_op(16'h0000, 32'h7, lat);
        check_result("p0_i7", 32'h0, 32'h7, 1'b1);

        // Backpressure: valid held 5 cycles, a request pulse during DONE is ignored
        @(negedge iCLOCK);
        iDATA_BUSY = 1'b1;
        do_op(16'h000C, 32'h00000095, lat);
        check_result("bp", 32'h90, 32'h5, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(posedge iCLOCK);
            @(negedge iCLOCK);
            check("bp_valid_held", 64'(oDATA_VALID), 1);
            check("bp_sq_stable", 64'(oDATA_SQ), 64'h90);
            if (j == 1) begin
                iDATA_REQ = 1'b1;
                iDATA_P = 16'h0009;
                iDATA_I = 32'h51;
            end
            if (j == 2) iDATA_REQ = 1'b0;
        end
        iDATA_BUSY = 1'b0;
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        check("bp_consumed", 64'(oDATA_VALID), 0);
        check("bp_req_ignored", 64'(oDATA_BUSY), 0);

        // Reset during CALC at counter 7
        @(negedge iCLOCK);
        iDATA_REQ = 1'b1;
        iDATA_P = 16'h00FF;
        iDATA_I = 32'hFE01;
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        iDATA_REQ = 1'b0;
        repeat (7) @(posedge iCLOCK);
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b1;
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b0;
        check("abort_busy", 64'(oDATA_BUSY), 0);
        check("abort_valid", 64'(oDATA_VALID), 0);
        check("abort_sq", 64'(oDATA_SQ), 0);
        check("abort_rem", 64'(oDATA_REM), 0);
        repeat (20) begin
            @(posedge iCLOCK);
            @(negedge iCLOCK);
            check("abort_no_valid", 64'(oDATA_VALID), 0);
        end
        do_op(16'h0004, 32'h10, lat);
        check_result("post_rst", 32'h10, 32'h0, 1'b0);
        @(posedge iCLOCK);

        // Back-to-back stream with REQ held high
        vrise_q.delete();
        vsq_q.delete();
        @(negedge iCLOCK);
        base = m_accepts;
        iDATA_REQ = 1'b1;
        iDATA_P = 16'h0007;
        iDATA_I = 32'd50;
        for (int n = 1; n <= 3; n++) begin
            k = 0;
            while (m_accepts < base + n && k < 40) begin
                @(negedge iCLOCK);
                k++;
            end
            check("b2b_accept", 64'(m_accepts), 64'(base + n));
            if (n == 1) begin
                iDATA_P = 16'h000A;
                iDATA_I = 32'd121;
            end else if (n == 2) begin
                iDATA_P = 16'hFFFF;
                iDATA_I = 32'hFFFE0001;
            end else begin
                iDATA_REQ = 1'b0;
            end
        end
        repeat (25) @(negedge iCLOCK);
        check("b2b_count", 64'(vrise_q.size()), 3);
        if (vrise_q.size() == 3) begin
            check("b2b_gap1", 64'(vrise_q[1] - vrise_q[0]), 19);
            check("b2b_gap2", 64'(vrise_q[2] - vrise_q[1]), 19);
            check("b2b_sq0", 64'(vsq_q[0]), 64'd49);
            check("b2b_sq1", 64'(vsq_q[1]), 64'd100);
            check("b2b_sq2", 64'(vsq_q[2]), 64'hFFFE0001);
        end
        check("b2b_last_rem", 64'(oDATA_REM), 0);
        check("b2b_idle", 64'(oDATA_BUSY), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
